// File: rtl/cfg_write_arbiter_if.sv
// Write-request handshake bundle for the two config-register requesters (A: SPI, B: sequencer).
interface cfg_write_arbiter_if;
  logic       a_valid;
  logic [6:0] a_addr;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [6:0] b_addr;
  logic [7:0] b_data;
  logic       b_ready;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/cfg_write_arbiter.sv
// Two-requester write arbiter into five 8-bit config registers; one write per IDLE/WRITE/ACK pass.
module cfg_write_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  cfg_write_arbiter_if.slave  req,
  output logic [7:0]          en_reg_out_7_0,
  output logic [7:0]          en_reg_out_15_8,
  output logic [7:0]          en_reg_pwm_7_0,
  output logic [7:0]          en_reg_pwm_15_8,
  output logic [7:0]          pwm_duty_cycle,
  output logic [3:0]          bad_addr_cnt,
  output logic                last_grant,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       last_grant_q, last_grant_d;
  logic       sel_b;

  logic [7:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
  logic [3:0] bad_cnt_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    last_grant_d = last_grant_q;
    sel_b        = 1'b0;
    case (state_q)
      StIdle: begin
        if (req.a_valid || req.b_valid) begin
          // Round-robin ties go to whichever requester was not served last.
          if (FIXED_PRIO) sel_b = !req.a_valid;
          else            sel_b = req.b_valid && (!req.a_valid || !last_grant_q);
          grant_d = sel_b;
          addr_d  = sel_b ? req.b_addr : req.a_addr;
          data_d  = sel_b ? req.b_data : req.a_data;
          state_d = StWrite;
        end
      end
      StWrite: state_d = StAck;
      StAck: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      addr_q       <= 7'h00;
      data_q       <= 8'h00;
      last_grant_q <= 1'b1;
      out_lo_q     <= 8'h00;
      out_hi_q     <= 8'h00;
      pwm_lo_q     <= 8'h00;
      pwm_hi_q     <= 8'h00;
      duty_q       <= 8'h00;
      bad_cnt_q    <= 4'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      last_grant_q <= last_grant_d;
      if (state_q == StWrite) begin
        case (addr_q)
          7'h00:   out_lo_q <= data_q;
          7'h01:   out_hi_q <= data_q;
          7'h02:   pwm_lo_q <= data_q;
          7'h03:   pwm_hi_q <= data_q;
          7'h04:   duty_q   <= data_q;
          default: if (bad_cnt_q != 4'hF) bad_cnt_q <= bad_cnt_q + 4'h1;
        endcase
      end
    end
  end

  // Ready depends only on state; rst suppresses the pulse if it lands in ACK.
  always_comb begin
    req.a_ready = (state_q == StAck) && !grant_q && !rst;
    req.b_ready = (state_q == StAck) &&  grant_q && !rst;
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign bad_addr_cnt    = bad_cnt_q;
  assign last_grant      = last_grant_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench: round-robin instance (dut0) and fixed-priority instance (dut1) share clk/rst.
module tb_cfg_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfg_write_arbiter_if if0 ();
  cfg_write_arbiter_if if1 ();

  logic [7:0] r0 [5];
  logic [7:0] r1 [5];
  logic [3:0] bad0, bad1;
  logic       lg0, lg1, busy0, busy1;

  cfg_write_arbiter #(.FIXED_PRIO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req(if0),
    .en_reg_out_7_0(r0[0]), .en_reg_out_15_8(r0[1]), .en_reg_pwm_7_0(r0[2]),
    .en_reg_pwm_15_8(r0[3]), .pwm_duty_cycle(r0[4]),
    .bad_addr_cnt(bad0), .last_grant(lg0), .busy(busy0)
  );

  cfg_write_arbiter #(.FIXED_PRIO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req(if1),
    .en_reg_out_7_0(r1[0]), .en_reg_out_15_8(r1[1]), .en_reg_pwm_7_0(r1[2]),
    .en_reg_pwm_15_8(r1[3]), .pwm_duty_cycle(r1[4]),
    .bad_addr_cnt(bad1), .last_grant(lg1), .busy(busy1)
  );

  typedef struct {
    logic       av;
    logic [6:0] aa;
    logic [7:0] ad;
    logic       bv;
    logic [6:0] ba;
    logic [7:0] bd;
    logic       exp_grant;
    logic [3:0] exp_bad;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] mreg [5];
  int         n_total = 0;
  int         n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    if0.a_valid = 1'b0; if0.b_valid = 1'b0;
    if1.a_valid = 1'b0; if1.b_valid = 1'b0;
    if0.a_addr = '0; if0.a_data = '0; if0.b_addr = '0; if0.b_data = '0;
    if1.a_addr = '0; if1.a_data = '0; if1.b_addr = '0; if1.b_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) mreg[i] = 8'h00;
  endtask

  // One transaction on dut0: latency, winner, register model, then post-transfer state.
  task automatic run_vec(input vec_t v, input string tag);
    int         n;
    logic       got_a, got_b;
    logic [6:0] wa;
    logic [7:0] wd;
    @(negedge clk);
    if0.a_valid = v.av; if0.a_addr = v.aa; if0.a_data = v.ad;
    if0.b_valid = v.bv; if0.b_addr = v.ba; if0.b_data = v.bd;
    n = 0; got_a = 1'b0; got_b = 1'b0;
    while (n < 10 && !got_a && !got_b) begin
      @(negedge clk);
      n++;
      got_a = if0.a_ready;
      got_b = if0.b_ready;
    end
    check($sformatf("%s latency", tag), n, 2);
    check($sformatf("%s grant", tag), {got_a, got_b}, v.exp_grant ? 2'b01 : 2'b10);
    wa = v.exp_grant ? v.ba : v.aa;
    wd = v.exp_grant ? v.bd : v.ad;
    if (wa < 7'd5) mreg[wa[2:0]] = wd;
    for (int i = 0; i < 5; i++) check($sformatf("%s reg%0d", tag, i), r0[i], mreg[i]);
    @(negedge clk);
    if0.a_valid = 1'b0; if0.b_valid = 1'b0;
    check($sformatf("%s last_grant", tag), lg0, v.exp_grant);
    check($sformatf("%s bad_cnt", tag), bad0, v.exp_bad);
    check($sformatf("%s busy", tag), busy0, 1'b0);
  endtask

  initial begin
    int   ta, tb, overlap, cnt_a, cnt_b, ngr;
    logic drop_a, drop_b;
    logic [5:0] seq;

    vecs[0] = '{1'b1, 7'h04, 8'hA5, 1'b0, 7'h00, 8'h00, 1'b0, 4'd0};
    vecs[1] = '{1'b1, 7'h00, 8'h11, 1'b1, 7'h01, 8'h22, 1'b1, 4'd0};
    vecs[2] = '{1'b1, 7'h02, 8'h33, 1'b1, 7'h03, 8'h44, 1'b0, 4'd0};
    vecs[3] = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h03, 8'h44, 1'b1, 4'd0};
    vecs[4] = '{1'b1, 7'h7F, 8'h55, 1'b0, 7'h00, 8'h00, 1'b0, 4'd1};
    vecs[5] = '{1'b1, 7'h00, 8'h66, 1'b1, 7'h05, 8'h77, 1'b1, 4'd2};
    vecs[6] = '{1'b1, 7'h00, 8'h66, 1'b1, 7'h04, 8'h88, 1'b0, 4'd2};
    vecs[7] = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h00, 8'h99, 1'b1, 4'd2};

    idle_inputs();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) check($sformatf("reset reg%0d", i), r0[i], 8'h00);
    check("reset bad_cnt", bad0, 4'h0);
    check("reset last_grant", lg0, 1'b1);
    check("reset last_grant fixed", lg1, 1'b1);
    check("reset busy", busy0, 1'b0);
    check("reset ready", {if0.a_ready, if0.b_ready}, 2'b00);
    rst = 1'b0;

    // Tie straight out of reset: A first, B three cycles later.
    @(negedge clk);
    if0.a_valid = 1'b1; if0.a_addr = 7'h00; if0.a_data = 8'h11;
    if0.b_valid = 1'b1; if0.b_addr = 7'h01; if0.b_data = 8'h22;
    ta = -1; tb = -1; overlap = 0; drop_a = 1'b0; drop_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (drop_a) if0.a_valid = 1'b0;
      if (drop_b) if0.b_valid = 1'b0;
      if (if0.a_ready && if0.b_ready) overlap++;
      if (if0.a_ready && ta < 0) begin ta = c; drop_a = 1'b1; end
      if (if0.b_ready && tb < 0) begin tb = c; drop_b = 1'b1; end
    end
    check("tie a_ready cycle", ta, 2);
    check("tie b_ready cycle", tb, 5);
    check("tie overlap", overlap, 0);
    check("tie reg0", r0[0], 8'h11);
    check("tie reg1", r0[1], 8'h22);
    check("tie last_grant", lg0, 1'b1);

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    do_reset();
    for (int i = 0; i < 17; i++) begin
      vec_t v;
      v = '{1'b1, 7'h05, 8'(i), 1'b0, 7'h00, 8'h00, 1'b0, (i >= 14) ? 4'd15 : 4'(i + 1)};
      run_vec(v, $sformatf("bad%0d", i));
    end

    // Continuous both-valid traffic must alternate A,B,A,B,...
    do_reset();
    @(negedge clk);
    if0.a_valid = 1'b1; if0.a_addr = 7'h02; if0.a_data = 8'h5A;
    if0.b_valid = 1'b1; if0.b_addr = 7'h03; if0.b_data = 8'hA5;
    seq = '0; ngr = 0; overlap = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (if0.a_ready && if0.b_ready) overlap++;
      if (if0.a_ready || if0.b_ready) begin
        seq = {seq[4:0], if0.b_ready};
        ngr++;
      end
    end
    if0.a_valid = 1'b0; if0.b_valid = 1'b0;
    check("alt grant count", ngr, 6);
    check("alt grant order", seq, 6'b010101);
    check("alt overlap", overlap, 0);
    repeat (4) @(negedge clk);

    // B raises valid during A's ACK; it must wait for the next IDLE.
    @(negedge clk);
    if0.a_valid = 1'b1; if0.a_addr = 7'h01; if0.a_data = 8'h3C;
    ta = -1; tb = -1; overlap = 0; drop_a = 1'b0; drop_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (drop_a) if0.a_valid = 1'b0;
      if (drop_b) if0.b_valid = 1'b0;
      if (c == ta + 1 && ta > 0) check("late idle after ack", busy0, 1'b0);
      if (if0.a_ready && if0.b_ready) overlap++;
      if (if0.a_ready && ta < 0) begin
        ta = c; drop_a = 1'b1;
        if0.b_valid = 1'b1; if0.b_addr = 7'h04; if0.b_data = 8'h7E;
      end
      if (if0.b_ready && tb < 0) begin tb = c; drop_b = 1'b1; end
    end
    check("late b delay", tb - ta, 3);
    check("late overlap", overlap, 0);
    check("late reg1", r0[1], 8'h3C);
    check("late reg4", r0[4], 8'h7E);

    // rst lands on the WRITE edge: nothing committed, no ready.
    @(negedge clk);
    if0.b_valid = 1'b1; if0.b_addr = 7'h03; if0.b_data = 8'hFF;
    @(negedge clk);
    check("rstmid busy in write", busy0, 1'b1);
    rst = 1'b1; if0.b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid busy", busy0, 1'b0);
    check("rstmid reg3", r0[3], 8'h00);
    cnt_b = 0;
    for (int c = 0; c < 6; c++) begin
      if (if0.b_ready) cnt_b++;
      @(negedge clk);
    end
    check("rstmid b_ready pulses", cnt_b, 0);

    // Fixed priority: A always wins while both stay valid.
    @(negedge clk);
    if1.a_valid = 1'b1; if1.a_addr = 7'h02; if1.a_data = 8'hC3;
    if1.b_valid = 1'b1; if1.b_addr = 7'h00; if1.b_data = 8'h3C;
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (if1.a_ready) cnt_a++;
      if (if1.b_ready) cnt_b++;
    end
    if1.a_valid = 1'b0; if1.b_valid = 1'b0;
    check("fixed a grants", cnt_a, 10);
    check("fixed b grants", cnt_b, 0);
    check("fixed reg2", r1[2], 8'hC3);
    check("fixed reg0", r1[0], 8'h00);
    check("fixed last_grant", lg1, 1'b0);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/cfg_write_arbiter.md
CFG_WRITE_ARBITER -- requirements
Module: cfg_write_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, 0 = round-robin between requesters, 1 = requester A always wins.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Ports: a_valid  input  1 / a_addr  input  7 / a_data  input  8  requester A write request (SPI-decoded writes).
REQ-005 Port: a_ready  output  1  write accepted for A; transfer completes when a_valid && a_ready.
REQ-006 Ports: b_valid  input  1 / b_addr  input  7 / b_data  input  8 / b_ready  output  1  requester B (on-chip sequencer), same rules as A.
REQ-007 Ports: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  config registers at addresses 0x00-0x04.
REQ-008 Port: bad_addr_cnt  output  4  count of writes with address >= 0x05.
REQ-009 Port: last_grant  output  1  requester of most recent completed write (0 = A, 1 = B).
REQ-010 Port: busy  output  1  high whenever state != IDLE.

Function
REQ-011 FSM states IDLE, WRITE, ACK; all transitions on rising clk.
REQ-012 IDLE: no valid -> stay; any valid -> select winner, latch its addr/data and grant id, go WRITE.
REQ-013 Selection, FIXED_PRIO=0: one valid -> that requester; both valid -> requester != last_grant.
REQ-014 Selection, FIXED_PRIO=1: both valid -> A.
REQ-015 WRITE: latched addr 0x00-0x04 -> update that register with latched data; else bad_addr_cnt +1, saturating at 15, no register change; always go ACK.
REQ-016 ACK: ready of granted requester high for exactly this one cycle; other ready low; last_grant <= grant id; go IDLE.
REQ-017 a_ready/b_ready decoded from state only (no combinational path from valid inputs); never both high.
REQ-018 Latency: valid sampled at edge N -> register updated at edge N+1 -> ready high during cycle after N+1 -> transfer at edge N+2.
REQ-019 Throughput: at most one write per 3 cycles; continuous both-valid traffic with FIXED_PRIO=0 strictly alternates A,B,A,B.
REQ-020 Requesters hold valid/addr/data stable until ready; arbiter ignores input changes after latch; write commits even if valid drops after latch.
REQ-021 Valid asserted by the non-granted requester during WRITE/ACK is held off, considered at next IDLE.
REQ-022 Register outputs change only in WRITE; hold value otherwise.
REQ-023 Only the 7-bit address is compared; no wrap or alias (0x85 does not exist, 0x7F is bad).

Reset
REQ-024 rst high at rising clk: state IDLE, all five registers 0x00, bad_addr_cnt 0, last_grant 1 (so A wins first tie), ready outputs 0, busy 0.
REQ-025 rst during WRITE or ACK: pending write discarded, no ready pulse issued; if rst coincides with WRITE edge, register is not updated.
REQ-026 rst has priority over every other event in the same cycle.

Verification
REQ-027 Single write: A writes addr 0x04 data 0xA5 -> pwm_duty_cycle = 0xA5 one edge after latch, a_ready pulses one cycle, last_grant 0.
REQ-028 Tie, round-robin: A (0x00,0x11) and B (0x01,0x22) valid together after reset -> A served first, then B; en_reg_out_7_0 = 0x11, en_reg_out_15_8 = 0x22, b_ready pulses 3 cycles after a_ready.
REQ-029 Tie, FIXED_PRIO=1: A and B held valid continuously, A resends 0x02 -> all grants to A, b_ready never high.
REQ-030 Bad address: 17 writes to 0x05 -> bad_addr_cnt saturates at 15, all registers unchanged, each write still acknowledged.
REQ-031 Reset mid-operation: B write 0x03/0xFF, rst asserted in WRITE cycle -> en_reg_pwm_15_8 = 0x00, b_ready never pulses, busy 0 next cycle.
REQ-032 Late request: B valid during A's ACK -> B latched on first IDLE cycle, completes 3 cycles later; no ready overlap.
